// File: rtl/param_pipeline_core_if.sv
// param_pipeline_core_if: run control, instruction-memory load, debug read and retire signals
interface param_pipeline_core_if #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 32
);
    localparam int AW = $clog2(IMEM_DEPTH);
    logic              run;
    logic              imem_we;
    logic [AW-1:0]     imem_waddr;
    logic [31:0]       imem_wdata;
    logic [3:0]        dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic [31:0]       pc;
    logic              retire_valid;
    logic [3:0]        retire_rd;
    logic [DATA_W-1:0] retire_data;
    logic              halted;
    modport master (
        output run, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        input  dbg_rdata, pc, retire_valid, retire_rd, retire_data, halted
    );
    modport slave (
        input  run, imem_we, imem_waddr, imem_wdata, dbg_raddr,
        output dbg_rdata, pc, retire_valid, retire_rd, retire_data, halted
    );
endinterface

// File: rtl/param_pipeline_core.sv
// param_pipeline_core: four-stage IF/ID/EX/WB integer pipeline with HALT and run freeze
// PIPE_FWD_EN defined: WB->EX operand forwarding; undefined: one-cycle ID stall on EX hazards
module param_pipeline_core #(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 16,
    parameter int IMEM_DEPTH = 32
) (
    input logic clk,
    input logic reset,
    param_pipeline_core_if.slave bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(NREGS);
    localparam logic [31:0] PC_LAST = 32'(IMEM_DEPTH * 4 - 4);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_LDI = 4'h2, OP_AND = 4'h3,
                           OP_OR = 4'h4, OP_ADDI = 4'h5, OP_HALT = 4'hF;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs [NREGS];
    logic [31:0]       pc, if_ir, id_ir;
    logic              if_v, id_v, ex_v, wb_v, halted;
    logic [3:0]        ex_op, id_op;
    logic [RW-1:0]     ex_rd, wb_rd, id_rd, id_rs1, id_rs2;
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm, wb_data, id_a, id_b, id_imm, op_a, op_b, ex_res;
    logic              ex_we, ex_halt, stall;

    assign id_op  = id_ir[31:28];
    assign id_rd  = id_ir[24 +: RW];
    assign id_rs1 = id_ir[20 +: RW];
    assign id_rs2 = id_ir[16 +: RW];
    assign id_imm = DATA_W'({{48{id_ir[15]}}, id_ir[15:0]});
    // register read with write-through of the instruction retiring this cycle; r0 is never written
    assign id_a   = (wb_v && wb_rd == id_rs1) ? wb_data : regs[id_rs1];
    assign id_b   = (wb_v && wb_rd == id_rs2) ? wb_data : regs[id_rs2];

    assign ex_we   = ex_v && ex_op <= OP_ADDI && ex_rd != '0;
    assign ex_halt = ex_v && ex_op == OP_HALT;

`ifdef PIPE_FWD_EN
    logic [RW-1:0] ex_rs1, ex_rs2;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (bus.run) begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    assign stall = 1'b0;
    assign op_a  = (wb_v && wb_rd == ex_rs1) ? wb_data : ex_a;
    assign op_b  = (wb_v && wb_rd == ex_rs2) ? wb_data : ex_b;
`else
    logic id_use1, id_use2;
    assign id_use1 = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI};
    assign id_use2 = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign stall   = id_v && ex_we && ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
    assign op_a    = ex_a;
    assign op_b    = ex_b;
`endif

    assign ex_res = ex_op == OP_ADD ? op_a + op_b :
                    ex_op == OP_SUB ? op_a - op_b :
                    ex_op == OP_LDI ? ex_imm :
                    ex_op == OP_AND ? op_a & op_b :
                    ex_op == OP_OR  ? op_a | op_b : op_a + ex_imm;

    // instruction memory survives reset and accepts writes even while frozen
    always_ff @(posedge clk)
        if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc      <= '0;
            if_v    <= 1'b0;
            id_v    <= 1'b0;
            ex_v    <= 1'b0;
            wb_v    <= 1'b0;
            halted  <= 1'b0;
            if_ir   <= '0;
            id_ir   <= '0;
            ex_op   <= '0;
            ex_rd   <= '0;
            ex_a    <= '0;
            ex_b    <= '0;
            ex_imm  <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.run) begin
            if (wb_v) regs[wb_rd] <= wb_data;
            halted <= halted | ex_halt;
            if (ex_halt) begin
                if_v <= 1'b0;
                id_v <= 1'b0;
            end else if (!stall) begin
                if_v  <= !halted;
                id_v  <= if_v;
                id_ir <= if_ir;
                if (!halted) begin
                    if_ir <= imem[pc[AW+1:2]];
                    pc    <= pc == PC_LAST ? '0 : pc + 32'd4;
                end
            end
            ex_v    <= id_v && !stall && !ex_halt;
            ex_op   <= id_op;
            ex_rd   <= id_rd;
            ex_a    <= id_a;
            ex_b    <= id_b;
            ex_imm  <= id_imm;
            wb_v    <= ex_we;
            wb_rd   <= ex_rd;
            wb_data <= ex_res;
        end

    assign bus.pc           = pc;
    assign bus.halted       = halted;
    assign bus.retire_valid = bus.run && wb_v;
    assign bus.retire_rd    = 4'(wb_rd);
    assign bus.retire_data  = wb_data;
    assign bus.dbg_rdata    = regs[bus.dbg_raddr[RW-1:0]];
endmodule

// File: tb/tb_param_pipeline_core.sv
// tb_param_pipeline_core: scoreboard bench; an in-order program interpreter predicts every retire
module tb_param_pipeline_core;
    localparam int DW = 32;
`ifdef PIPE_FWD_EN
    localparam int ADD_LAT = 5;
`else
    localparam int ADD_LAT = 6;
`endif
    typedef struct { logic [3:0] rd; logic [DW-1:0] data; } ret_t;

    logic clk = 1'b0, reset = 1'b1;
    int cyc = 0, t0 = 0, errors = 0, checks = 0;
    ret_t exp_q[$];
    ret_t e_m;
    int ret_cyc[$];
    int base[3];
    logic [DW-1:0] m_regs [16];
    logic [31:0] prog [32];

    param_pipeline_core_if #(.DATA_W(DW), .IMEM_DEPTH(32)) bus_if ();
    param_pipeline_core dut (.clk(clk), .reset(reset), .bus(bus_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every retire pulse must match the head of the expected queue
    always @(negedge clk)
        if (!reset && bus_if.retire_valid) begin
            ret_cyc.push_back(cyc - t0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got rd=%0d data=%0h, expected no retire", bus_if.retire_rd, bus_if.retire_data);
            end else begin
                e_m = exp_q.pop_front();
                check("retire_rd", bus_if.retire_rd, e_m.rd);
                check("retire_data", bus_if.retire_data, e_m.data);
            end
        end

    function automatic logic [31:0] ins(input logic [3:0] op, rd, rs1, rs2, input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    function automatic logic [DW-1:0] sext(input logic [15:0] v);
        return {{(DW-16){v[15]}}, v};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [3:0] op = 4'($urandom_range(0, 7));
        return {op, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 16'($urandom)};
    endfunction

    // architectural interpretation: straight-line execution until HALT
    task automatic model(input int n);
        foreach (m_regs[i]) m_regs[i] = '0;
        for (int a = 0; a < n; a++) begin
            logic [31:0] w;
            logic [DW-1:0] x, y, v;
            w = prog[a];
            x = m_regs[w[23:20]];
            y = m_regs[w[19:16]];
            if (w[31:28] == 4'hF) break;
            case (w[31:28])
                4'h0: v = x + y;
                4'h1: v = x - y;
                4'h2: v = sext(w[15:0]);
                4'h3: v = x & y;
                4'h4: v = x | y;
                4'h5: v = x + sext(w[15:0]);
                default: continue;
            endcase
            if (w[27:24] == 4'h0) continue;
            m_regs[w[27:24]] = v;
            exp_q.push_back('{w[27:24], v});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.run = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load();
        for (int a = 0; a < 32; a++) begin
            bus_if.imem_we = 1'b1;
            bus_if.imem_waddr = 5'(a);
            bus_if.imem_wdata = prog[a];
            step();
        end
        bus_if.imem_we = 1'b0;
    endtask

    task automatic start();
        ret_cyc.delete();
        t0 = cyc + 1;
        bus_if.run = 1'b1;
    endtask

    task automatic fill_nop();
        foreach (prog[i]) prog[i] = 32'h6000_0000;
    endtask

    task automatic run_to_halt(input int budget, input bit gaps);
        logic [31:0] p;
        int n = 0;
        while (!bus_if.halted && n < budget) begin
            bus_if.run = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            n++;
        end
        bus_if.run = 1'b1;
        check("halted", bus_if.halted, 1);
        repeat (4) step();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        p = bus_if.pc;
        repeat (3) step();
        check("pc_frozen", bus_if.pc, p);
        for (int r = 0; r < 16; r++) begin
            bus_if.dbg_raddr = 4'(r);
            #1;
            check($sformatf("reg%0d", r), bus_if.dbg_rdata, m_regs[r]);
        end
    endtask

    initial begin
        int n;
        bus_if.run = 1'b0;
        bus_if.imem_we = 1'b0;
        bus_if.imem_waddr = '0;
        bus_if.imem_wdata = '0;
        bus_if.dbg_raddr = '0;
        step();
        check("rst_pc", bus_if.pc, 0);
        check("rst_retire_valid", bus_if.retire_valid, 0);
        check("rst_retire_rd", bus_if.retire_rd, 0);
        check("rst_retire_data", bus_if.retire_data, 0);
        check("rst_halted", bus_if.halted, 0);

        // dependent ADD: latency and result
        fill_nop();
        prog[0] = ins(4'h2, 4'd1, 4'd0, 4'd0, 16'd5);
        prog[1] = ins(4'h2, 4'd2, 4'd0, 4'd0, 16'd7);
        prog[2] = ins(4'h0, 4'd3, 4'd1, 4'd2, 16'd0);
        prog[3] = 32'hF000_0000;
        do_reset();
        load();
        check("pc_held_run_low", bus_if.pc, 0);
        model(32);
        start();
        run_to_halt(200, 1'b0);
        check("add_latency", ret_cyc.size() > 2 ? ret_cyc[2] : -1, ADD_LAT);
        for (int i = 0; i < 3; i++) base[i] = ret_cyc.size() > i ? ret_cyc[i] : -100;

        // same program, three frozen cycles early on: everything shifts by three
        do_reset();
        model(32);
        start();
        step();
        step();
        bus_if.run = 1'b0;
        repeat (3) step();
        run_to_halt(200, 1'b0);
        for (int i = 0; i < 3; i++)
            check($sformatf("shifted_retire%0d", i), ret_cyc.size() > i ? ret_cyc[i] : -1, base[i] + 3);

        // wrap-around arithmetic
        fill_nop();
        prog[0] = ins(4'h2, 4'd1, 4'd0, 4'd0, 16'hFFFF);
        prog[1] = ins(4'h5, 4'd1, 4'd1, 4'd0, 16'd1);
        prog[2] = 32'hF000_0000;
        do_reset();
        load();
        model(32);
        start();
        run_to_halt(200, 1'b0);

        // writes to r0 vanish
        fill_nop();
        prog[0] = ins(4'h2, 4'd0, 4'd0, 4'd0, 16'd9);
        prog[1] = ins(4'h2, 4'd5, 4'd0, 4'd0, 16'd3);
        prog[2] = ins(4'h0, 4'd6, 4'd0, 4'd5, 16'd0);
        prog[3] = 32'hF000_0000;
        do_reset();
        load();
        model(32);
        start();
        run_to_halt(200, 1'b0);

        // HALT in the last word
        fill_nop();
        prog[31] = 32'hF000_0000;
        do_reset();
        load();
        model(32);
        start();
        run_to_halt(200, 1'b0);

        // no HALT: pc wraps from 0x7C to 0
        fill_nop();
        do_reset();
        load();
        model(32);
        start();
        n = 0;
        while (bus_if.pc != 32'h7C && n < 100) begin
            step();
            n++;
        end
        check("pc_reach_7c", bus_if.pc, 32'h7C);
        step();
        check("pc_wrap", bus_if.pc, 0);

        // reset with ADD in EX, then rerun from preserved imem
        fill_nop();
        prog[0] = ins(4'h2, 4'd1, 4'd0, 4'd0, 16'd5);
        prog[1] = ins(4'h2, 4'd2, 4'd0, 4'd0, 16'd7);
        prog[4] = ins(4'h0, 4'd3, 4'd1, 4'd2, 16'd0);
        prog[5] = 32'hF000_0000;
        do_reset();
        load();
        model(32);
        void'(exp_q.pop_back());
        start();
        repeat (7) step();
        reset = 1'b1;
        #1;
        check("mid_reset_pc", bus_if.pc, 0);
        check("mid_reset_retire", bus_if.retire_valid, 0);
        for (int r = 1; r < 4; r++) begin
            bus_if.dbg_raddr = 4'(r);
            #1;
            check($sformatf("mid_reset_reg%0d", r), bus_if.dbg_rdata, 0);
        end
        check("mid_reset_queue", exp_q.size(), 0);
        exp_q.delete();
        do_reset();
        model(32);
        start();
        run_to_halt(200, 1'b0);

        // random programs with random run gaps
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(4, 24);
            foreach (prog[i]) prog[i] = rand_instr();
            prog[n] = 32'hF000_0000;
            do_reset();
            load();
            model(32);
            start();
            run_to_halt(400, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_pipeline_core.md
PARAM_PIPELINE_CORE -- requirements
Module: param_pipeline_core

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width (8..64).
REQ-002 Parameter NREGS, default 16, register count, power of two, 2..16.
REQ-003 Parameter IMEM_DEPTH, default 32, instruction words, power of two.
REQ-004 clk input 1: clock; all state updates on rising edge.
REQ-005 reset input 1: reset, asynchronous, active-high.
REQ-006 run input 1: pipeline advance enable; low freezes all pipeline state.
REQ-007 imem_we input 1: instruction memory write strobe.
REQ-008 imem_waddr input log2(IMEM_DEPTH): word address for write.
REQ-009 imem_wdata input 32: instruction word for write.
REQ-010 dbg_raddr input 4: debug register read address.
REQ-011 dbg_rdata output DATA_W: combinational register file read, write-through not applied.
REQ-012 pc output 32: current fetch byte address.
REQ-013 retire_valid output 1: one-cycle pulse per register write in WB.
REQ-014 retire_rd output 4 / retire_data output DATA_W: WB destination and value.
REQ-015 halted output 1: high once HALT executed; sticky until reset.

Function
REQ-016 Four stages IF, ID, EX, WB, each with a valid bit; one instruction per stage.
REQ-017 Instruction fields: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm; register fields use low log2(NREGS) bits.
REQ-018 Opcodes: 0 ADD rs1+rs2; 1 SUB rs1-rs2; 2 LOADI sign-extended imm; 3 AND; 4 OR; 5 ADDI rs1+sext(imm); F HALT; all others NOP (no write).
REQ-019 Arithmetic modulo 2^DATA_W; imm sign-extended/truncated to DATA_W.
REQ-020 Register 0 reads zero; writes to rd=0 discarded, no retire pulse.
REQ-021 IF reads imem[pc>>2]; pc advances by 4, wrapping to 0 after IMEM_DEPTH*4-4.
REQ-022 ID reads register file with write-through: WB write to same register in same cycle supplies new value.
REQ-023 Latency fetch-to-retire 3 cycles after fetch edge, absent stalls.
REQ-024 HALT in EX: halted set next edge; IF/ID valid bits cleared; fetch stops; older WB instruction completes.
REQ-025 run low: pc, stage registers, halted hold; no retire pulse; imem writes still accepted.
REQ-026 imem write and fetch of same address in one cycle: fetch returns old word.

Reset
REQ-027 Reset asserted: pc=0, all valid bits 0, all registers 0, halted=0, retire_valid=0, retire_rd=0, retire_data=0.
REQ-028 Reset mid-execution discards all in-flight instructions; imem contents preserved.
REQ-029 First fetch occurs on first rising edge after reset deasserts with run high.

Configuration
REQ-030 Macro PIPE_FWD_EN defined: EX operands forwarded from WB result when WB valid, writes, and rd matches rs; zero stalls for any dependency.
REQ-031 PIPE_FWD_EN undefined: ID stalls (IF, ID hold; bubble into EX) while EX instruction valid, writes, and rd matches nonzero rs1/rs2 used; one-cycle stall per such hazard.

Verification
REQ-032 Load LOADI r1,5; LOADI r2,7; ADD r3,r1,r2; HALT -> retire r3=12; with PIPE_FWD_EN, ADD retires cycle 5 after first fetch; without, cycle 6.
REQ-033 LOADI r1,0x7FFF_FFFF... (DATA_W=32: LOADI r1,-1; ADDI r1,r1,1) -> retire r1=0 (wrap).
REQ-034 LOADI r0,9 -> no retire pulse; dbg_raddr=0 reads 0.
REQ-035 Deassert run for 3 cycles mid-stream -> pc and retire sequence identical to uninterrupted run, shifted 3 cycles.
REQ-036 HALT at address 0x7C with IMEM_DEPTH=32 -> halted=1, pc frozen, no further retire; separate run without HALT shows pc wrap 0x7C->0x00.
REQ-037 Assert reset while ADD in EX -> no retire, registers zero, pc=0 next cycle.
